// File: rtl/weight_init_seq_if.sv
// Write port between the weight initialiser and the weight RAM.
// The master drives the request; the RAM side answers with wr_ready.
interface weight_init_seq_if #(
    parameter int ADDR_W = 8
) ();
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic signed [15:0]  wr_data;
    logic                wr_ready;

    modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/weight_init_seq.sv
// Fills a weight RAM of DEPTH words with scaled signed random samples.
// One sample is taken per accepted write; samples offered during a stall are dropped.
module weight_init_seq #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int SHIFT  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [15:0]              rand_in,
    weight_init_seq_if.master        wr,
    output logic                     busy,
    output logic                     done
);
    localparam int DATA_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    function automatic logic signed [DATA_W-1:0] scale_sample(input logic signed [DATA_W-1:0] s);
        return s >>> SHIFT;
    endfunction

    logic [1:0] state;
    logic       accept;

    assign accept = wr.wr_en & wr.wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wr.wr_en   <= 1'b0;
            wr.wr_addr <= '0;
            wr.wr_data <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_FILL;
                        wr.wr_addr <= '0;
                        wr.wr_data <= scale_sample($signed(rand_in));
                        wr.wr_en   <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_FILL: begin
                    // A stalled request holds address and data; only an accept consumes a sample.
                    if (accept) begin
                        if (wr.wr_addr == LAST_ADDR) begin
                            state    <= ST_DONE;
                            wr.wr_en <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            wr.wr_addr <= wr.wr_addr + 1'b1;
                            wr.wr_data <= scale_sample($signed(rand_in));
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_init_seq.sv
// Bench for weight_init_seq: a small DEPTH=4/SHIFT=4 instance and a full DEPTH=256/SHIFT=0 instance.
module tb_weight_init_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_s = 1'b0;
    logic        start_b = 1'b0;
    logic [15:0] rand_in = 16'h0;
    logic        ready = 1'b0;
    logic        busy_s, done_s, busy_b, done_b;
    bit          sel = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    int          q_addr[$];
    logic [15:0] q_data[$];

    weight_init_seq_if #(.ADDR_W(2)) s_if ();
    weight_init_seq_if #(.ADDR_W(8)) b_if ();

    assign s_if.wr_ready = ready;
    assign b_if.wr_ready = ready;

    weight_init_seq #(.DEPTH(4), .ADDR_W(2), .SHIFT(4)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_s), .rand_in(rand_in),
        .wr(s_if.master), .busy(busy_s), .done(done_s));

    weight_init_seq #(.DEPTH(256), .ADDR_W(8), .SHIFT(0)) u_big (
        .clk(clk), .rst_n(rst_n), .start(start_b), .rand_in(rand_in),
        .wr(b_if.master), .busy(busy_b), .done(done_b));

    always #5 clk = ~clk;

    logic        cur_en, cur_busy, cur_done;
    logic [31:0] cur_addr;
    logic [15:0] cur_data;

    always_comb begin
        cur_en   = sel ? b_if.wr_en : s_if.wr_en;
        cur_addr = sel ? 32'(b_if.wr_addr) : 32'(s_if.wr_addr);
        cur_data = sel ? b_if.wr_data : s_if.wr_data;
        cur_busy = sel ? busy_b : busy_s;
        cur_done = sel ? done_b : done_s;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Floor division by 2^sh on the two's-complement value, truncated to 16 bits.
    function automatic logic [15:0] model_scale(input logic [15:0] r, input int sh);
        int sv, p, res;
        sv = (r[15]) ? (int'(r) - 65536) : int'(r);
        p  = 1 << sh;
        res = (sv >= 0) ? (sv / p) : -((-sv + p - 1) / p);
        return res[15:0];
    endfunction

    task automatic set_start(input logic v);
        if (sel) start_b = v; else start_s = v;
    endtask

    task automatic do_fill(input int stall_at, input int stall_n, input int restart_at,
                           input bit restart_done, input bit use_pat);
        logic [15:0] pat [4];
        logic [15:0] r;
        int d, sh, lat, stalls, writes;
        pat = '{16'h8000, 16'h7FF0, 16'h0010, 16'hFFFF};
        d = sel ? 256 : 4;
        sh = sel ? 0 : 4;
        lat = 0; stalls = 0; writes = 0;
        r = use_pat ? pat[0] : 16'($urandom);
        set_start(1'b1); rand_in = r; ready = 1'b1;
        q_addr.push_back(0); q_data.push_back(model_scale(r, sh));
        @(negedge clk); lat++; set_start(1'b0);
        for (int k = 0; k < d; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    ready = 1'b0; rand_in = 16'($urandom);
                    @(negedge clk); lat++; stalls++;
                    check_eq("stall_en", 32'(cur_en), 32'd1);
                    check_eq("stall_addr", cur_addr, 32'(q_addr[0]));
                    check_eq("stall_data", 32'(cur_data), 32'(q_data[0]));
                end
            end
            check_eq("wr_en", 32'(cur_en), 32'd1);
            check_eq("busy", 32'(cur_busy), 32'd1);
            check_eq("done_low", 32'(cur_done), 32'd0);
            if (q_addr.size() == 0) begin
                check_eq("sb_empty", 32'd0, 32'd1);
            end else begin
                check_eq("wr_addr", cur_addr, 32'(q_addr.pop_front()));
                check_eq("wr_data", 32'(cur_data), 32'(q_data.pop_front()));
                writes++;
            end
            ready = 1'b1;
            r = (use_pat && k + 1 < 4) ? pat[k+1] : 16'($urandom);
            rand_in = r;
            if (k == restart_at) set_start(1'b1);
            if (k < d - 1) begin
                q_addr.push_back(k + 1); q_data.push_back(model_scale(r, sh));
            end
            @(negedge clk); lat++; set_start(1'b0);
        end
        check_eq("done_pulse", 32'(cur_done), 32'd1);
        check_eq("busy_fall", 32'(cur_busy), 32'd0);
        check_eq("en_fall", 32'(cur_en), 32'd0);
        check_eq("latency", 32'(lat - stalls), 32'(d + 1));
        check_eq("write_count", 32'(writes), 32'(d));
        if (restart_done) set_start(1'b1);
        @(negedge clk); set_start(1'b0);
        check_eq("done_end", 32'(cur_done), 32'd0);
        check_eq("idle_en", 32'(cur_en), 32'd0);
        @(negedge clk);
        check_eq("idle_en2", 32'(cur_en), 32'd0);
        check_eq("idle_busy", 32'(cur_busy), 32'd0);
        check_eq("sb_drained", 32'(q_addr.size()), 32'd0);
    endtask

    initial begin
        #1;
        for (int i = 0; i < 2; i++) begin
            sel = bit'(i);
            #1;
            check_eq("rst_en", 32'(cur_en), 32'd0);
            check_eq("rst_addr", cur_addr, 32'd0);
            check_eq("rst_data", 32'(cur_data), 32'd0);
            check_eq("rst_busy", 32'(cur_busy), 32'd0);
            check_eq("rst_done", 32'(cur_done), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        sel = 1'b0;
        do_fill(-1, 0, -1, 1'b0, 1'b1);
        do_fill(1, 3, -1, 1'b0, 1'b0);
        do_fill(-1, 0, 2, 1'b1, 1'b0);

        // Abort the large instance while it presents address 5.
        sel = 1'b1;
        set_start(1'b1); rand_in = 16'($urandom); ready = 1'b1;
        @(negedge clk); set_start(1'b0);
        for (int k = 0; k < 5; k++) begin
            rand_in = 16'($urandom);
            @(negedge clk);
        end
        check_eq("pre_rst_addr", cur_addr, 32'd5);
        rst_n = 1'b0;
        #1;
        check_eq("async_en", 32'(cur_en), 32'd0);
        check_eq("async_addr", cur_addr, 32'd0);
        check_eq("async_data", 32'(cur_data), 32'd0);
        check_eq("async_busy", 32'(cur_busy), 32'd0);
        check_eq("async_done", 32'(cur_done), 32'd0);
        @(negedge clk);
        check_eq("rst_no_done", 32'(cur_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_done", 32'(cur_done), 32'd0);

        do_fill(-1, 0, -1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
